display_msg_arbiter: RTL
========================

Name: display_msg_arbiter

Overview:
- Time-shares the 4-digit seven-segment display between two sources.
- The persistent base source is, for example, the score or timer.
- The transient message source presents hex words through a valid/ready handshake. Each message is shown for a fixed hold time and can optionally blink.
- Registered outputs hexs/points/LEs drive the display driver's inputs directly. LEs bit = 1 blanks that digit.

Parameters:
- HOLD_CYCLES, 50_000_000: cycles each message stays on screen. Must be ≥ 2.
- BLINK_HALF, 12_500_000: cycles per blink half-period (on or off). Must be ≥ 1.
- CNT_W, 26: width of the hold and blink counters. Must hold HOLD_CYCLES-1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- base_hexs  in  16  base digits, digit 3 in [15:12]
- base_points  in  4  base decimal points
- base_LEs  in  4  base per-digit blank
- msg_valid  in  1  message offered
- msg_ready  out  1  block can accept a message
- msg_hexs  in  16  message digits
- msg_points  in  4  message decimal points
- msg_blink  in  1  message blinks while shown
- msg_flush  in  1  drop active and pending messages
- busy  out  1  a message is on screen
- msg_done  out  1  one-cycle pulse when a message's hold time ends
- hexs  out  16  to display driver
- points  out  4  to display driver
- LEs  out  4  to display driver

Behaviour:
- Reset (async, immediate):
  - state = BASE; active and pending slots empty; counters = 0; blink phase = ON.
  - Outputs: hexs = 0, points = 0, LEs = 4'hF (all blank), busy = 0, msg_done = 0.
  - msg_ready = 1.
  - Reset mid-message discards both slots; no msg_done is produced.
- Storage: one active slot and one pending slot, each holding {hexs, points, blink}.
- msg_ready = !pending_full. It is combinational from a register only, never from msg_valid.
- Transfer occurs on the rising edge where msg_valid && msg_ready.
- State BASE:
  - Each cycle, hexs/points/LEs are updated from the base_* inputs, giving 1-cycle latency.
  - A transfer loads the active slot, clears the counters, sets phase = ON, and moves to SHOW.
  - The first message value appears on the outputs in the cycle after the transfer edge.
- State SHOW:
  - busy = 1.
  - hexs/points come from the active slot. LEs = 4'h0 when phase = ON or blink = 0; otherwise LEs = 4'hF.
  - Base inputs are ignored.
  - hold_cnt increments each cycle.
  - If blink = 1, blink_cnt increments each cycle. When blink_cnt reaches BLINK_HALF-1, it wraps to 0 and phase toggles.
  - A transfer during SHOW writes the pending slot.
  - Expiry occurs on the edge where hold_cnt == HOLD_CYCLES-1. The message is therefore visible for exactly HOLD_CYCLES output cycles.
- At expiry:
  - msg_done = 1 for the following cycle.
  - If the pending slot is full: pending → active, pending cleared, counters cleared, phase = ON, stay in SHOW.
  - Else, if a transfer happens on the same edge: the new message bypasses directly into the active slot and the block stays in SHOW.
  - Else: go to BASE. Base values appear on the next cycle and busy falls.
- Transfer into a full pending slot is impossible because msg_ready = 0.
- Flush:
  - msg_flush = 1 at an edge clears both slots and goes to BASE. No msg_done is produced.
  - Flush has priority over expiry and over a transfer on the same edge. The transfer is dropped, but the handshake still counts as completed.
- msg_done is registered and never asserted in BASE except in the cycle after an expiry.
- The counters never wrap past HOLD_CYCLES-1.

Test Plan (HOLD_CYCLES = 8, BLINK_HALF = 2):
- Release reset with base_hexs = 16'h1234, base_LEs = 0.
  - During reset: LEs = F, hexs = 0.
  - One cycle after release: hexs = 1234, LEs = 0, msg_ready = 1.
- Single message: send msg_hexs = 16'hABCD, blink = 0.
  - hexs = ABCD for exactly 8 cycles, busy = 1.
  - msg_done pulses once in the cycle hexs returns to 1234.
- Blink: send a message with blink = 1.
  - LEs sequence = 0, 0, F, F, 0, 0, F, F over the 8 cycles, then base LEs.
- Back-to-back:
  - Send m1 = 1111, then m2 = 2222 while m1 is shown. msg_ready drops after m2 is accepted; an m3 offered is held off.
  - Outputs: 8 cycles of 1111, then 8 cycles of 2222 with no base cycle between; two msg_done pulses.
- Same-edge bypass:
  - Offer m = 5555 exactly on the expiry edge with pending empty.
  - 5555 follows the previous message directly; busy stays 1.
- Flush and reset:
  - Assert msg_flush on cycle 3 of a message with pending full → next cycle base values, busy = 0, msg_ready = 1, no msg_done.
  - Repeat using rst instead of msg_flush → LEs = F immediately.

Source files
------------

// File: rtl/display_msg_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : display_msg_arbiter_if
//  Description : Message-source handshake bundle for display_msg_arbiter.
//                master = message producer, slave = arbiter.
//                  msg_valid  : message offered
//                  msg_ready  : arbiter can accept a message
//                  msg_hexs   : message digits, digit 3 in [15:12]
//                  msg_points : message decimal points
//                  msg_blink  : message blinks while shown
//                  msg_flush  : drop active and pending messages
//                  busy       : a message is on screen
//                  msg_done   : one-cycle pulse when a message's hold ends
//  Revision    : 1.0 - initial release
// ============================================================================
interface display_msg_arbiter_if;
  logic        msg_valid;
  logic        msg_ready;
  logic [15:0] msg_hexs;
  logic [3:0]  msg_points;
  logic        msg_blink;
  logic        msg_flush;
  logic        busy;
  logic        msg_done;

  modport master (
    output msg_valid, msg_hexs, msg_points, msg_blink, msg_flush,
    input  msg_ready, busy, msg_done
  );

  modport slave (
    input  msg_valid, msg_hexs, msg_points, msg_blink, msg_flush,
    output msg_ready, busy, msg_done
  );
endinterface
`default_nettype wire

// File: rtl/display_msg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : display_msg_arbiter
//  Description : Time-shares a 4-digit seven-segment display between a
//                persistent base source and transient messages. Each message
//                is shown for HOLD_CYCLES cycles, optionally blinking with a
//                half-period of BLINK_HALF cycles. One active and one pending
//                message slot.
//  Ports       : clk, rst        - clock, asynchronous active-high reset
//                base_hexs/points/LEs - base display content (LEs=1 blanks)
//                msg             - message handshake bundle (slave side)
//                hexs/points/LEs - registered outputs to the display driver
//  Revision    : 1.0 - initial release
// ============================================================================
module display_msg_arbiter #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int BLINK_HALF  = 12_500_000,
  parameter int CNT_W       = 26
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic [15:0]         base_hexs,
  input  wire logic [3:0]          base_points,
  input  wire logic [3:0]          base_LEs,
  display_msg_arbiter_if.slave     msg,
  output logic      [15:0]         hexs,
  output logic      [3:0]          points,
  output logic      [3:0]          LEs
);

  localparam logic [CNT_W-1:0] C_HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_BLINK_LAST = CNT_W'(BLINK_HALF - 1);
  localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_BASE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  state_t           r_state;
  logic [15:0]      r_act_hexs;
  logic [3:0]       r_act_points;
  logic             r_act_blink;
  logic [15:0]      r_pend_hexs;
  logic [3:0]       r_pend_points;
  logic             r_pend_blink;
  logic             r_pend_full;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] r_blink_cnt;
  logic             r_phase_on;
  logic             r_busy;
  logic             r_done;

  logic w_xfer;
  logic w_expire;
  logic w_blink_wrap;
  logic w_phase_next;

  // Ready depends only on the pending-slot flag, never on msg_valid.
  assign msg.msg_ready = !r_pend_full;
  assign msg.busy      = r_busy;
  assign msg.msg_done  = r_done;

  assign w_xfer       = msg.msg_valid && !r_pend_full;
  assign w_expire     = (r_state == ST_SHOW) && (r_hold_cnt == C_HOLD_LAST);
  assign w_blink_wrap = r_act_blink && (r_blink_cnt == C_BLINK_LAST);
  // Outputs are registered, so LEs is computed from the phase the next
  // cycle will have rather than the current one.
  assign w_phase_next = w_blink_wrap ? ~r_phase_on : r_phase_on;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_BASE;
      r_act_hexs    <= '0;
      r_act_points  <= '0;
      r_act_blink   <= 1'b0;
      r_pend_hexs   <= '0;
      r_pend_points <= '0;
      r_pend_blink  <= 1'b0;
      r_pend_full   <= 1'b0;
      r_hold_cnt    <= '0;
      r_blink_cnt   <= '0;
      r_phase_on    <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      hexs          <= '0;
      points        <= '0;
      LEs           <= 4'hF;
    end else begin
      r_done <= 1'b0;
      if (msg.msg_flush) begin
        // Flush wins over expiry and over a same-edge transfer; the
        // transfer handshake completes but its data is discarded.
        r_state      <= ST_BASE;
        r_act_hexs   <= '0;
        r_act_points <= '0;
        r_act_blink  <= 1'b0;
        r_pend_full  <= 1'b0;
        r_hold_cnt   <= '0;
        r_blink_cnt  <= '0;
        r_phase_on   <= 1'b1;
        r_busy       <= 1'b0;
        hexs         <= base_hexs;
        points       <= base_points;
        LEs          <= base_LEs;
      end else begin
        case (r_state)
          ST_BASE: begin
            r_hold_cnt  <= '0;
            r_blink_cnt <= '0;
            r_phase_on  <= 1'b1;
            if (w_xfer) begin
              r_state      <= ST_SHOW;
              r_act_hexs   <= msg.msg_hexs;
              r_act_points <= msg.msg_points;
              r_act_blink  <= msg.msg_blink;
              r_busy       <= 1'b1;
              hexs         <= msg.msg_hexs;
              points       <= msg.msg_points;
              LEs          <= 4'h0;
            end else begin
              r_busy <= 1'b0;
              hexs   <= base_hexs;
              points <= base_points;
              LEs    <= base_LEs;
            end
          end

          ST_SHOW: begin
            if (w_expire) begin
              r_done      <= 1'b1;
              r_hold_cnt  <= '0;
              r_blink_cnt <= '0;
              r_phase_on  <= 1'b1;
              if (r_pend_full) begin
                r_act_hexs   <= r_pend_hexs;
                r_act_points <= r_pend_points;
                r_act_blink  <= r_pend_blink;
                r_pend_full  <= 1'b0;
                hexs         <= r_pend_hexs;
                points       <= r_pend_points;
                LEs          <= 4'h0;
              end else if (w_xfer) begin
                // Same-edge bypass straight into the active slot.
                r_act_hexs   <= msg.msg_hexs;
                r_act_points <= msg.msg_points;
                r_act_blink  <= msg.msg_blink;
                hexs         <= msg.msg_hexs;
                points       <= msg.msg_points;
                LEs          <= 4'h0;
              end else begin
                r_state <= ST_BASE;
                r_busy  <= 1'b0;
                hexs    <= base_hexs;
                points  <= base_points;
                LEs     <= base_LEs;
              end
            end else begin
              r_hold_cnt <= r_hold_cnt + C_ONE;
              if (r_act_blink) begin
                r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + C_ONE;
                r_phase_on  <= w_phase_next;
              end
              if (w_xfer) begin
                r_pend_hexs   <= msg.msg_hexs;
                r_pend_points <= msg.msg_points;
                r_pend_blink  <= msg.msg_blink;
                r_pend_full   <= 1'b1;
              end
              hexs   <= r_act_hexs;
              points <= r_act_points;
              LEs    <= (r_act_blink && !w_phase_next) ? 4'hF : 4'h0;
            end
          end

          default: begin
            r_state <= ST_BASE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
